serial_subtractor: RTL and testbench

//   Bit-serial W-bit subtractor computing diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b) behind a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  // Minuend shifts out of the LSB while difference bits fill in from the MSB,
  // so one register serves as both operand and partial result.
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] bsh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             bff_reg;
  logic             d_bit, b_next, last_bit, accept;

  assign d_bit    = work_reg[0] ^ bsh_reg[0] ^ bff_reg;
  assign b_next   = (~work_reg[0] & bsh_reg[0]) | (~(work_reg[0] ^ bsh_reg[0]) & bff_reg);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign accept   = start && (state_reg != SHIFT);

  generate
    if (WIDTH == 1) begin : g_w1
      assign work_next = d_bit;
    end else begin : g_wn
      assign work_next = {d_bit, work_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_reg, b_msb_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end else if (state_reg == SHIFT && last_bit) begin
      // d_bit is the result MSB on the final shift cycle
      ovf <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ d_bit);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg <= '0;
      bsh_reg  <= '0;
      cnt_reg  <= '0;
      bff_reg  <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
    end else if (accept) begin
      work_reg <= a;
      bsh_reg  <= b;
      cnt_reg  <= '0;
      bff_reg  <= 1'b0;
    end else if (state_reg == SHIFT) begin
      work_reg <= work_next;
      bsh_reg  <= bsh_reg >> 1;
      bff_reg  <= b_next;
      if (last_bit) begin
        diff   <= work_next;
        borrow <= b_next;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake corner
// cases, randomized ops against an arithmetic model, plus a WIDTH=1 instance.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done, borrow;
  logic [W-1:0] a, b, diff;
  logic start1, busy1, done1, borrow1;
  logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf, ovf1;
`endif

  serial_subtractor #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the full operands.
  task automatic model(input logic [7:0] va, input logic [7:0] vb,
                       output logic [7:0] d, output logic br, output logic ov);
    int sd;
    d  = va - vb;
    br = (int'(va) < int'(vb));
    sd = int'($signed(va)) - int'($signed(vb));
    ov = (sd > 127) || (sd < -128);
  endtask

  task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed,
                     input logic eb, input logic eo, input string tag);
    logic [7:0] held;
    int n, busy_cnt, changes;
    bit seen;
    held = diff; busy_cnt = 0; changes = 0; seen = 0;
    @(negedge clk); a = va; b = vb; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (n = 1; n <= W + 4; n++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (busy) busy_cnt++;
      if (diff !== held) changes++;
    end
    if (!seen) n = 99;
    chk({tag, " latency"}, n, W + 1);
    chk({tag, " busy_cycles"}, busy_cnt, W);
    chk({tag, " diff_held_during_shift"}, changes, 0);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, " ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: %s ovf unknown", tag);
`endif
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " diff_held_after"}, diff, ed);
    $display("op %s: a=%02h b=%02h diff=%02h borrow=%0b latency=%0d", tag, va, vb, diff, borrow, n);
  endtask

  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
  endtask

  vec_t tbl[6];
  vec_t t1[4];

  initial begin
    int n, dcount, first_n;
    logic [7:0] ra, rb, md;
    logic mb, mo;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    t1[0]  = '{8'h0, 8'h0, 8'h0, 1'b0, 1'b0};
    t1[1]  = '{8'h0, 8'h1, 8'h1, 1'b1, 1'b1};
    t1[2]  = '{8'h1, 8'h0, 8'h1, 1'b0, 1'b0};
    t1[3]  = '{8'h1, 8'h1, 8'h0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset borrow", borrow, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      op8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].br, tbl[i].ov, $sformatf("vec%0d", i));

    // Back-to-back: restart in the DONE cycle.
    @(negedge clk); a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n);
    chk("b2b first latency", n, W + 1);
    chk("b2b first diff", diff, 8'h00);
    chk("b2b first borrow", borrow, 0);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n);
    chk("b2b second latency", n, W + 1);
    chk("b2b second diff", diff, 8'hFF);
    $display("op b2b: diff=%02h latency=%0d", diff, n);

    // start during SHIFT must be ignored.
    @(negedge clk); a = 8'h5A; b = 8'h21; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dcount = 0; first_n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 4) begin a = 8'h00; b = 8'hFF; start = 1'b1; end
      if (i == 5) start = 1'b0;
      if (done) begin
        dcount++;
        if (first_n == 99) begin
          first_n = i;
          chk("ignore diff", diff, 8'h39);
          chk("ignore borrow", borrow, 0);
        end
      end
    end
    chk("ignore latency", first_n, W + 1);
    chk("ignore done_count", dcount, 1);
    chk("ignore diff_final", diff, 8'h39);
    $display("op ignore: diff=%02h done_count=%0d", diff, dcount);

    // Asynchronous reset mid-SHIFT.
    @(negedge clk); a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst diff", diff, 0);
    chk("midrst borrow", borrow, 0);
    chk("midrst done", done, 0);
    @(negedge clk); rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midrst no_done", dcount, 0);
    $display("op midrst: done_count=%0d", dcount);
    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model(ra, rb, md, mb, mo);
      op8(ra, rb, md, mb, mo, $sformatf("rnd%0d", i));
    end

    // WIDTH=1 instance.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a1 = t1[i].a[0:0]; b1 = t1[i].b[0:0]; start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      n = 99;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (done1) begin n = k; break; end
      end
      chk($sformatf("w1_%0d latency", i), n, 2);
      chk($sformatf("w1_%0d diff", i), diff1, t1[i].d[0:0]);
      chk($sformatf("w1_%0d borrow", i), borrow1, t1[i].br);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("w1_%0d ovf", i), ovf1, t1[i].ov);
`endif
      $display("op w1_%0d: a=%0b b=%0b diff=%0b borrow=%0b latency=%0d", i, a1, b1, diff1, borrow1, n);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
